flip_candidate_sequencer: RTL and testbench
===========================================

FLIP_CANDIDATE_SEQUENCER -- requirements
Module: flip_candidate_sequencer

Interface
REQ-001 SHALL have parameter NSAT, default 3, literals per clause; only 3 is supported, and elaboration SHALL fail otherwise.
REQ-002 SHALL have parameter MAX_CLAUSES_PER_VARIABLE (MC), default 20, occurrence-list width.
REQ-003 SHALL have parameter VAR_BITS, default 16, variable index width.
REQ-004 SHALL have parameter TIMEOUT, default 64, memory-wait limit in cycles (used only with the macro).
REQ-005 SHALL have ports: clk in 1, clock; reset_n in 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports: start_i in 1; ready_o out 1; clause_vars_i in NSAT*VAR_BITS (literal k at [k*VAR_BITS +: VAR_BITS]); clause_vars_valid_i in NSAT.
REQ-007 SHALL have ports: mem_req_o out 1; mem_addr_o out VAR_BITS; mem_rdata_valid_i in 1; mem_rdata_broken_i in MC; mem_rdata_mask_i in MC.
REQ-008 SHALL have ports to the flip selector: clause_broken_o out MC; mask_bits_o out MC; wren_o out clog2(NSAT); break_values_valid_o out NSAT; selected_i in clog2(NSAT).
REQ-009 SHALL have ports: flip_valid_o out 1; flip_ready_i in 1; flip_var_o out VAR_BITS; flip_idx_o out clog2(NSAT); error_o out 1.

Function
REQ-010 SHALL implement an FSM with states IDLE, FETCH, WAIT, WRITE, SETTLE and DONE; ready_o SHALL be 1 only in IDLE.
REQ-011 On start_i&ready_o, SHALL latch clause_vars_i and clause_vars_valid_i, set literal counter k=0, and go to FETCH, or directly to WRITE if valid[0]=0.
REQ-012 FETCH: SHALL assert mem_req_o for exactly one cycle with mem_addr_o=var[k], then go to WAIT.
REQ-013 WAIT: on mem_rdata_valid_i, SHALL register broken/mask data and go to WRITE; mem_rdata_valid_i in any other state SHALL be ignored.
REQ-014 WRITE: SHALL drive the registered broken/mask on clause_broken_o/mask_bits_o for one cycle. wren_o SHALL be 1<<k for k<NSAT-1 and all ones for k=NSAT-1; wren_o SHALL be 0 in every other state.
REQ-015 Invalid literal (valid[k]=0): SHALL skip FETCH/WAIT and WRITE zeros for broken and mask.
REQ-016 break_values_valid_o SHALL equal the latched valid mask during the final WRITE and 0 otherwise.
REQ-017 After a non-final WRITE, SHALL increment k and go to FETCH or WRITE per valid[k]; after the final WRITE, SHALL go to SETTLE.
REQ-018 SETTLE (selected_i valid this cycle): SHALL register flip_idx_o=selected_i and flip_var_o=var[selected_i], then go to DONE. If selected_i>=NSAT or valid[selected_i]=0, SHALL set error_o=1 and flip_var_o=0.
REQ-019 DONE: SHALL hold flip_valid_o=1 with stable outputs until flip_ready_i, then go to IDLE; a start_i asserted in the same cycle SHALL be ignored.
REQ-020 Latency: with all literals valid and rdata_valid the cycle after mem_req_o, flip_valid_o SHALL rise 3*NSAT+2 = 11 cycles after the start handshake; each invalid literal SHALL reduce this by 2.
REQ-021 error_o SHALL be a sticky status for the current job, cleared on the next accepted start.

Reset
REQ-022 reset_n low SHALL asynchronously force IDLE with k=0 and all outputs 0, except ready_o=1; this includes wren_o=0, which SHALL prevent selector writes.
REQ-023 Reset mid-job SHALL abandon the job, with no flip_valid_o and any pending memory response ignored.

Configuration
REQ-024 With macro FLIP_SEQ_TIMEOUT_EN defined: a counter SHALL run in WAIT, and reaching TIMEOUT cycles SHALL set error_o, skip to DONE with flip_var_o=0 and flip_idx_o=0, and produce no further wren_o.
REQ-025 Without FLIP_SEQ_TIMEOUT_EN: WAIT SHALL wait indefinitely, no counter logic SHALL exist, and TIMEOUT SHALL be unused.

Structure
REQ-026 Shared package sat_pkg SHALL hold NSAT, MC, VAR_BITS and the FSM state typedef.
REQ-027 SHALL be a single flat module (FSM plus datapath) with no sub-module; the flip selector SHALL be instantiated alongside it at the next level up, not inside it.

Verification
REQ-028 vars={5,9,12}, valid=111, 1-cycle memory, selected_i=01 in SETTLE -> mem_addr_o 5,9,12; wren_o sequence 01,10,11; flip_var_o=9; flip_valid_o at cycle 11.
REQ-029 valid=101 -> no fetch for literal 1; WRITE zeros with wren_o=10; break_values_valid_o=101 on final write; flip_valid_o at cycle 9.
REQ-030 selected_i=11 in SETTLE -> error_o=1, flip_var_o=0, flip_valid_o=1.
REQ-031 flip_ready_i held low 5 cycles -> flip_valid_o and outputs stable; start_i during DONE is ignored; accepted in IDLE afterwards.
REQ-032 reset_n pulsed low during WAIT of literal 1 -> immediate IDLE, wren_o=0; late mem_rdata_valid_i ignored; next job completes normally.
REQ-033 With FLIP_SEQ_TIMEOUT_EN and TIMEOUT=4, no mem_rdata_valid_i -> error_o=1 and DONE after 4 WAIT cycles; without the macro -> FSM remains in WAIT.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared SAT constants and the sequencer state encoding.
package sat_pkg;

  localparam int unsigned NSAT     = 3;   // literals per clause
  localparam int unsigned MC       = 20;  // occurrence-list width per variable
  localparam int unsigned VAR_BITS = 16;  // variable index width

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    SETTLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/flip_candidate_sequencer.sv
// flip_candidate_sequencer
//   Walks the literals of one clause. For each valid literal it fetches that
//   variable's broken/mask occurrence lists and streams them into the flip
//   selector, one write per literal. It then captures the selector's choice
//   and offers the chosen variable on a valid/ready handshake.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start_i / ready_o     job handshake (ready_o high only in IDLE)
//   clause_vars_i         NSAT variable indices, literal k at [k*VAR_BITS +: VAR_BITS]
//   clause_vars_valid_i   per-literal valid mask
//   mem_req_o, mem_addr_o one-cycle fetch request for a variable's lists
//   mem_rdata_*_i         fetch response (valid strobe, broken list, mask list)
//   clause_broken_o, mask_bits_o, wren_o, break_values_valid_o
//                         selector write port; selected_i is its answer
//   flip_valid_o / flip_ready_i, flip_var_o, flip_idx_o, error_o
//                         result handshake; error_o is sticky until the next start
//
// Build option
//   FLIP_SEQ_TIMEOUT_EN   bounds the memory wait to TIMEOUT cycles; on expiry the
//                         job ends in DONE with error_o set and a zero result.
module flip_candidate_sequencer #(
  parameter int unsigned NSAT                     = sat_pkg::NSAT,
  parameter int unsigned MAX_CLAUSES_PER_VARIABLE = sat_pkg::MC,
  parameter int unsigned VAR_BITS                 = sat_pkg::VAR_BITS,
  parameter int unsigned TIMEOUT                  = 64,
  localparam int unsigned MC    = MAX_CLAUSES_PER_VARIABLE,
  localparam int unsigned IDX_W = $clog2(NSAT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic [NSAT*VAR_BITS-1:0] clause_vars_i,
  input  logic [NSAT-1:0]          clause_vars_valid_i,
  output logic                     mem_req_o,
  output logic [VAR_BITS-1:0]      mem_addr_o,
  input  logic                     mem_rdata_valid_i,
  input  logic [MC-1:0]            mem_rdata_broken_i,
  input  logic [MC-1:0]            mem_rdata_mask_i,
  output logic [MC-1:0]            clause_broken_o,
  output logic [MC-1:0]            mask_bits_o,
  output logic [IDX_W-1:0]         wren_o,
  output logic [NSAT-1:0]          break_values_valid_o,
  input  logic [IDX_W-1:0]         selected_i,
  output logic                     flip_valid_o,
  input  logic                     flip_ready_i,
  output logic [VAR_BITS-1:0]      flip_var_o,
  output logic [IDX_W-1:0]         flip_idx_o,
  output logic                     error_o
);

  import sat_pkg::*;

  // Only 3-SAT is supported; TIMEOUT must be a usable cycle count.
  if (NSAT != 3) begin : g_bad_nsat
    $error("flip_candidate_sequencer: NSAT must be 3");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("flip_candidate_sequencer: TIMEOUT must be nonzero");
  end

  seq_state_t                state;
  logic [IDX_W-1:0]          k;
  logic [NSAT*VAR_BITS-1:0]  vars_q;
  logic [NSAT-1:0]           valid_q;

  logic [IDX_W-1:0]          k_inc;
  logic                      last_k;
  logic [VAR_BITS-1:0]       nxt_var;
  logic                      nxt_valid;
  logic [VAR_BITS-1:0]       sel_var;
  logic                      sel_ok;

`ifdef FLIP_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Selector write enable: one-hot per literal, all ones on the last literal.
  function automatic logic [IDX_W-1:0] wren_for(input logic [IDX_W-1:0] kk);
    if (kk == IDX_W'(NSAT - 1)) wren_for = '1;
    else                        wren_for = IDX_W'(1) << kk;
  endfunction

  assign k_inc  = k + IDX_W'(1);
  assign last_k = (k == IDX_W'(NSAT - 1));

  // Look up the next literal and the selector's pick; out-of-range picks stay invalid.
  always_comb begin
    nxt_var   = '0;
    nxt_valid = 1'b0;
    sel_var   = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NSAT; i++) begin
      if (k_inc == IDX_W'(i)) begin
        nxt_var   = vars_q[i*VAR_BITS +: VAR_BITS];
        nxt_valid = valid_q[i];
      end
      if (selected_i == IDX_W'(i)) begin
        sel_var = vars_q[i*VAR_BITS +: VAR_BITS];
        sel_ok  = valid_q[i];
      end
    end
  end

  // Sequencer FSM; every output is registered on entry to the state that owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      k                    <= '0;
      vars_q               <= '0;
      valid_q              <= '0;
      ready_o              <= 1'b1;
      mem_req_o            <= 1'b0;
      mem_addr_o           <= '0;
      clause_broken_o      <= '0;
      mask_bits_o          <= '0;
      wren_o               <= '0;
      break_values_valid_o <= '0;
      flip_valid_o         <= 1'b0;
      flip_var_o           <= '0;
      flip_idx_o           <= '0;
      error_o              <= 1'b0;
`ifdef FLIP_SEQ_TIMEOUT_EN
      tmo_cnt              <= '0;
`endif
    end else begin
      // Single-cycle strobes and write data default low.
      mem_req_o            <= 1'b0;
      mem_addr_o           <= '0;
      clause_broken_o      <= '0;
      mask_bits_o          <= '0;
      wren_o               <= '0;
      break_values_valid_o <= '0;

      case (state)
        IDLE: begin
          if (start_i && ready_o) begin
            vars_q     <= clause_vars_i;
            valid_q    <= clause_vars_valid_i;
            k          <= '0;
            ready_o    <= 1'b0;
            error_o    <= 1'b0;
            flip_var_o <= '0;
            flip_idx_o <= '0;
            if (clause_vars_valid_i[0]) begin
              state      <= FETCH;
              mem_req_o  <= 1'b1;
              mem_addr_o <= clause_vars_i[VAR_BITS-1:0];
            end else begin
              state  <= WRITE;
              wren_o <= wren_for('0);
            end
          end
        end

        FETCH: begin
          state <= WAIT;
`ifdef FLIP_SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end

        WAIT: begin
          if (mem_rdata_valid_i) begin
            state           <= WRITE;
            clause_broken_o <= mem_rdata_broken_i;
            mask_bits_o     <= mem_rdata_mask_i;
            wren_o          <= wren_for(k);
            if (last_k) break_values_valid_o <= valid_q;
          end
`ifdef FLIP_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // Memory never answered: abandon the remaining writes.
            state        <= DONE;
            error_o      <= 1'b1;
            flip_valid_o <= 1'b1;
            flip_var_o   <= '0;
            flip_idx_o   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        WRITE: begin
          if (last_k) begin
            state <= SETTLE;
          end else begin
            k <= k_inc;
            if (nxt_valid) begin
              state      <= FETCH;
              mem_req_o  <= 1'b1;
              mem_addr_o <= nxt_var;
            end else begin
              // Invalid literal: write zero lists without touching memory.
              wren_o <= wren_for(k_inc);
              if (k_inc == IDX_W'(NSAT - 1)) break_values_valid_o <= valid_q;
            end
          end
        end

        SETTLE: begin
          state        <= DONE;
          flip_valid_o <= 1'b1;
          flip_idx_o   <= selected_i;
          if (sel_ok) begin
            flip_var_o <= sel_var;
          end else begin
            flip_var_o <= '0;
            error_o    <= 1'b1;
          end
        end

        DONE: begin
          if (flip_ready_i) begin
            state        <= IDLE;
            flip_valid_o <= 1'b0;
            ready_o      <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flip_candidate_sequencer.sv
// Randomized self-checking bench for flip_candidate_sequencer.
// The reference model derives fetch order, write contents, result and latency
// directly from the clause contents; the memory is a behavioural responder.
module tb_flip_candidate_sequencer;

  localparam int unsigned VB  = 16;
  localparam int unsigned MCW = 20;
  localparam int unsigned TMO = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start_i;
  logic            ready_o;
  logic [3*VB-1:0] clause_vars_i;
  logic [2:0]      clause_vars_valid_i;
  logic            mem_req_o;
  logic [VB-1:0]   mem_addr_o;
  logic            mem_rdata_valid_i;
  logic [MCW-1:0]  mem_rdata_broken_i;
  logic [MCW-1:0]  mem_rdata_mask_i;
  logic [MCW-1:0]  clause_broken_o;
  logic [MCW-1:0]  mask_bits_o;
  logic [1:0]      wren_o;
  logic [2:0]      break_values_valid_o;
  logic [1:0]      selected_i;
  logic            flip_valid_o;
  logic            flip_ready_i;
  logic [VB-1:0]   flip_var_o;
  logic [1:0]      flip_idx_o;
  logic            error_o;

  int n_tests = 0;
  int n_fail  = 0;

  flip_candidate_sequencer #(.TIMEOUT(TMO)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start_i              (start_i),
    .ready_o              (ready_o),
    .clause_vars_i        (clause_vars_i),
    .clause_vars_valid_i  (clause_vars_valid_i),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .mem_rdata_valid_i    (mem_rdata_valid_i),
    .mem_rdata_broken_i   (mem_rdata_broken_i),
    .mem_rdata_mask_i     (mem_rdata_mask_i),
    .clause_broken_o      (clause_broken_o),
    .mask_bits_o          (mask_bits_o),
    .wren_o               (wren_o),
    .break_values_valid_o (break_values_valid_o),
    .selected_i           (selected_i),
    .flip_valid_o         (flip_valid_o),
    .flip_ready_i         (flip_ready_i),
    .flip_var_o           (flip_var_o),
    .flip_idx_o           (flip_idx_o),
    .error_o              (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents as a pure function of the variable index.
  function automatic logic [MCW-1:0] bfun(input logic [VB-1:0] a);
    return {a, 4'h0} ^ 20'h5A5A5;
  endfunction
  function automatic logic [MCW-1:0] mfun(input logic [VB-1:0] a);
    return {4'hC, ~a} ^ 20'h00F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete job, checked against the model, then a DONE hold phase.
  task automatic run_job(input logic [3*VB-1:0] vv, input logic [2:0] vl,
                         input logic [1:0] sel, input int d);
    logic [VB-1:0]  aq[$];
    logic [VB-1:0]  ev, lit, cur, hv;
    logic [MCW-1:0] eb, em;
    logic [1:0]     ew, hi;
    logic           ee, he, done;
    int             exp_lat, cyc, wi, pend, hold, s;

    exp_lat = 2;
    for (int j = 0; j < 3; j++) begin
      if (vl[j]) begin
        aq.push_back(vv[j*VB +: VB]);
        exp_lat += d + 2;
      end else begin
        exp_lat += 1;
      end
    end
    s = int'(sel);
    if (s < 3 && vl[s]) begin ev = vv[s*VB +: VB]; ee = 1'b0; end
    else                begin ev = '0;             ee = 1'b1; end

    chk("ready_before_start", 32'(ready_o), 32'd1);
    clause_vars_i       = vv;
    clause_vars_valid_i = vl;
    selected_i          = sel;
    start_i             = 1'b1;
    tick();
    start_i             = 1'b0;
    clause_vars_i       = {16'($urandom), 16'($urandom), 16'($urandom)};
    clause_vars_valid_i = 3'($urandom);
    cyc = 1; wi = 0; pend = 0; done = 1'b0; cur = '0;

    while (!done && cyc < 400) begin
      mem_rdata_valid_i = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rdata_valid_i  = 1'b1;
          mem_rdata_broken_i = bfun(cur);
          mem_rdata_mask_i   = mfun(cur);
        end
      end else if (!mem_req_o && $urandom_range(0, 3) == 0) begin
        // Stray response outside WAIT must be ignored.
        mem_rdata_valid_i  = 1'b1;
        mem_rdata_broken_i = 20'($urandom);
        mem_rdata_mask_i   = 20'($urandom);
      end

      if (mem_req_o) begin
        if (aq.size() == 0) begin
          chk("extra_fetch", 32'd1, 32'd0);
        end else begin
          cur = aq.pop_front();
          chk("fetch_addr", 32'(mem_addr_o), 32'(cur));
          pend = d;
        end
      end

      if (wren_o != 2'b00) begin
        if (wi > 2) begin
          chk("extra_write", 32'd1, 32'd0);
        end else begin
          ew  = (wi == 2) ? 2'b11 : 2'(1 << wi);
          lit = vv[wi*VB +: VB];
          eb  = vl[wi] ? bfun(lit) : '0;
          em  = vl[wi] ? mfun(lit) : '0;
          chk("wren", 32'(wren_o), 32'(ew));
          chk("broken", 32'(clause_broken_o), 32'(eb));
          chk("mask", 32'(mask_bits_o), 32'(em));
          chk("bvv", 32'(break_values_valid_o), (wi == 2) ? 32'(vl) : 32'd0);
        end
        wi++;
      end

      if (flip_valid_o) begin
        done = 1'b1;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("write_count", 32'(wi), 32'd3);
        chk("fetch_left", 32'(aq.size()), 32'd0);
        chk("flip_var", 32'(flip_var_o), 32'(ev));
        chk("flip_idx", 32'(flip_idx_o), 32'(sel));
        chk("error", 32'(error_o), 32'(ee));
      end else begin
        tick();
        cyc++;
      end
    end
    if (!done) chk("job_hang", 32'd0, 32'd1);
    mem_rdata_valid_i = 1'b0;

    // Hold results while the consumer stalls; a start here must be ignored.
    hv = flip_var_o; hi = flip_idx_o; he = error_o;
    hold = $urandom_range(0, 5);
    for (int h = 0; h < hold; h++) begin
      start_i             = 1'b1;
      clause_vars_valid_i = 3'b111;
      flip_ready_i        = 1'b0;
      tick();
      chk("hold_valid", 32'(flip_valid_o), 32'd1);
      chk("hold_var", 32'(flip_var_o), 32'(hv));
      chk("hold_idx", 32'(flip_idx_o), 32'(hi));
      chk("hold_err", 32'(error_o), 32'(he));
      chk("hold_ready", 32'(ready_o), 32'd0);
      chk("hold_req", 32'(mem_req_o), 32'd0);
    end
    start_i      = 1'b1;
    flip_ready_i = 1'b1;
    tick();
    start_i      = 1'b0;
    flip_ready_i = 1'b0;
    chk("release_valid", 32'(flip_valid_o), 32'd0);
    chk("release_ready", 32'(ready_o), 32'd1);
    chk("release_no_req", 32'(mem_req_o), 32'd0);
    chk("sticky_err", 32'(error_o), 32'(ee));
  endtask

  // Reset during WAIT of literal 1, then a late response that must be dropped.
  task automatic reset_mid_job();
    int nreq = 0;
    int pend = 0;
    clause_vars_i       = {16'd300, 16'd200, 16'd100};
    clause_vars_valid_i = 3'b111;
    start_i             = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 20 && nreq < 2; c++) begin
      mem_rdata_valid_i = 1'b0;
      if (pend > 0) begin
        mem_rdata_valid_i  = 1'b1;
        mem_rdata_broken_i = bfun(16'd100);
        mem_rdata_mask_i   = mfun(16'd100);
        pend = 0;
      end
      if (mem_req_o) begin
        nreq++;
        if (nreq < 2) pend = 1;
      end
      if (nreq < 2) tick();
    end
    chk("rst_reached_lit1", 32'(nreq), 32'd2);
    mem_rdata_valid_i = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_wren", 32'(wren_o), 32'd0);
    chk("rst_flip_valid", 32'(flip_valid_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    tick();
    reset_n            = 1'b1;
    mem_rdata_valid_i  = 1'b1;
    mem_rdata_broken_i = 20'hFFFFF;
    mem_rdata_mask_i   = 20'hFFFFF;
    tick();
    mem_rdata_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late_rsp_wren", 32'(wren_o), 32'd0);
      chk("late_rsp_ready", 32'(ready_o), 32'd1);
      chk("late_rsp_valid", 32'(flip_valid_o), 32'd0);
      tick();
    end
  endtask

  // Memory never answers.
  task automatic no_response_job();
    int  seen_wren = 0;
    int  first_v   = -1;
    clause_vars_i       = {16'd7, 16'd6, 16'd5};
    clause_vars_valid_i = 3'b111;
    selected_i          = 2'd1;
    start_i             = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 80 && first_v < 0; c++) begin
      if (wren_o != 2'b00) seen_wren++;
      if (flip_valid_o) first_v = c;
      else tick();
    end
    chk("tmo_no_write", 32'(seen_wren), 32'd0);
`ifdef FLIP_SEQ_TIMEOUT_EN
    chk("tmo_done_cycle", 32'(first_v), 32'(TMO + 2));
    chk("tmo_error", 32'(error_o), 32'd1);
    chk("tmo_var", 32'(flip_var_o), 32'd0);
    chk("tmo_idx", 32'(flip_idx_o), 32'd0);
    flip_ready_i = 1'b1;
    tick();
    flip_ready_i = 1'b0;
    chk("tmo_back_idle", 32'(ready_o), 32'd1);
`else
    chk("wait_forever_valid", 32'(flip_valid_o), 32'd0);
    chk("wait_forever_ready", 32'(ready_o), 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("wait_recover_ready", 32'(ready_o), 32'd1);
`endif
  endtask

  initial begin
    reset_n             = 1'b0;
    start_i             = 1'b0;
    clause_vars_i       = '0;
    clause_vars_valid_i = '0;
    mem_rdata_valid_i   = 1'b0;
    mem_rdata_broken_i  = '0;
    mem_rdata_mask_i    = '0;
    selected_i          = '0;
    flip_ready_i        = 1'b0;
    repeat (3) tick();
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_wren", 32'(wren_o), 32'd0);
    chk("reset_req", 32'(mem_req_o), 32'd0);
    chk("reset_valid", 32'(flip_valid_o), 32'd0);
    chk("reset_error", 32'(error_o), 32'd0);
    chk("reset_bvv", 32'(break_values_valid_o), 32'd0);
    reset_n = 1'b1;
    tick();

    run_job({16'd12, 16'd9, 16'd5}, 3'b111, 2'd1, 1);
    run_job({16'd12, 16'd9, 16'd5}, 3'b101, 2'd0, 1);
    run_job({16'd12, 16'd9, 16'd5}, 3'b111, 2'd3, 1);
    run_job({16'd40, 16'd41, 16'd42}, 3'b101, 2'd1, 2);
    run_job({16'd1, 16'd2, 16'd3}, 3'b000, 2'd2, 1);
    reset_mid_job();
    run_job({16'd300, 16'd200, 16'd100}, 3'b111, 2'd2, 1);

    for (int t = 0; t < 40; t++) begin
      run_job({16'($urandom), 16'($urandom), 16'($urandom)},
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)));
    end

    no_response_job();
    run_job({16'd77, 16'd66, 16'd55}, 3'b011, 2'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
